// File: rtl/issue_pkg.sv
// Shared types and constants for the issue-stage branch-ID allocator.
package issue_pkg;

    localparam int BID_W     = 4;
    localparam int BRT_DEPTH = 8;
    localparam int BRT_IDX_W = 3;

    typedef logic [BID_W-1:0]     bid_t;
    typedef logic [BRT_IDX_W-1:0] idx_t;

    typedef enum logic {
        ST_RUN,
        ST_RECOVER
    } alloc_state_t;

    // Table index of a branch ID: the ID with its wrap bit stripped.
    function automatic idx_t bid_idx(input bid_t bid);
        return bid[BRT_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/issue_bid_flushmask.sv
// Circular range mask over the branch record table: marks indices from
// start_idx up to (but excluding) the index of end_ptr, and additionally the
// end_ptr index itself when an allocation is being squashed in the same cycle.
module issue_bid_flushmask
    import issue_pkg::*;
(
    input  idx_t                 start_idx,
    input  bid_t                 end_ptr,
    input  logic                 alloc_fire,
    output logic [BRT_DEPTH-1:0] mask
);

    idx_t end_idx;
    idx_t span;
    idx_t offset;

    // Each index is set when its circular distance from start_idx lies inside the squashed span.
    always_comb begin
        mask    = '0;
        offset  = '0;
        end_idx = bid_idx(end_ptr);
        span    = idx_t'(end_idx - start_idx);
        for (int i = 0; i < BRT_DEPTH; i++) begin
            offset  = idx_t'(idx_t'(i) - start_idx);
            mask[i] = (offset < span) | (alloc_fire & (offset == span));
        end
    end

endmodule

// File: rtl/issue_bid_alloc.sv
// Branch-ID allocator and recovery tracker for the issue stage. Hands out
// wrap-tagged branch IDs, retires them in order on commit, and on a commit
// override rolls the write pointer back, pulses a flush mask of the younger
// branches and holds off allocation for RECOVER_CYCLES cycles.
module issue_bid_alloc
    import issue_pkg::*;
#(
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_alloc_req,
    output logic                 o_alloc_ready,
    output logic [BID_W-1:0]     o_alloc_bid,
    input  logic                 i_bc_valid,
    input  logic [BID_W-1:0]     i_bc_bid,
    input  logic                 i_bco_valid,
    input  logic [BID_W-1:0]     i_bco_bid,
    output logic                 o_flush_valid,
    output logic [BRT_DEPTH-1:0] o_flush_mask,
    output logic [BID_W-1:0]     o_count,
    output logic                 o_empty,
    output logic                 o_full,
    output logic                 o_err
);

    localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYCLES);

    bid_t                 wptr;
    bid_t                 rptr;
    alloc_state_t         state;
    alloc_state_t         state_next;
    logic [3:0]           rec_cnt;
    logic [3:0]           rec_cnt_next;

    logic                 empty;
    logic                 full;
    logic                 ready;
    logic                 fire;
    logic                 bc_ok;
    logic                 bco_paired;
    logic                 bco_ok;
    logic                 err_set;
    bid_t                 bco_next;
    logic [BRT_DEPTH-1:0] squash_mask;

    // Occupancy flags come straight from the pointer pair; the wrap bit tells full from empty.
    always_comb begin
        empty      = (wptr == rptr);
        full       = (bid_idx(wptr) == bid_idx(rptr)) & (wptr[BID_W-1] != rptr[BID_W-1]);
        ready      = (state == ST_RUN) & ~full;
        fire       = i_alloc_req & ready;
        bc_ok      = i_bc_valid & (i_bc_bid == rptr) & ~empty;
        bco_paired = i_bc_valid & (i_bco_bid == i_bc_bid);
        bco_ok     = i_bco_valid & bco_paired & bc_ok;
        err_set    = (i_bc_valid & ~bc_ok) | (i_bco_valid & ~bco_paired);
        bco_next   = bid_t'(i_bco_bid + 4'd1);
    end

    issue_bid_flushmask u_flushmask (
        .start_idx  (bid_idx(bco_next)),
        .end_ptr    (wptr),
        .alloc_fire (fire),
        .mask       (squash_mask)
    );

    // Pointer update: an override rewinds wptr past the mispredicted branch, overriding any same-cycle grant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (bc_ok) begin
                rptr <= bid_t'(rptr + 4'd1);
            end
            if (bco_ok) begin
                wptr <= bco_next;
            end else if (fire) begin
                wptr <= bid_t'(wptr + 4'd1);
            end
        end
    end

    // Recovery FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_RUN;
            rec_cnt <= '0;
        end else begin
            state   <= state_next;
            rec_cnt <= rec_cnt_next;
        end
    end

    // Recovery FSM next state: stay in RECOVER until the counter has counted down to its last cycle.
    always_comb begin
        state_next   = state;
        rec_cnt_next = rec_cnt;
        case (state)
            ST_RUN: begin
                if (bco_ok) begin
                    state_next   = ST_RECOVER;
                    rec_cnt_next = RECOVER_LOAD;
                end
            end
            ST_RECOVER: begin
                if (bco_ok) begin
                    rec_cnt_next = RECOVER_LOAD;
                end else if (rec_cnt <= 4'd1) begin
                    state_next   = ST_RUN;
                    rec_cnt_next = '0;
                end else begin
                    rec_cnt_next = rec_cnt - 4'd1;
                end
            end
            default: begin
                state_next   = ST_RUN;
                rec_cnt_next = '0;
            end
        endcase
    end

    // Registered flush pulse and the sticky protocol error flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_flush_valid <= 1'b0;
            o_flush_mask  <= '0;
            o_err         <= 1'b0;
        end else begin
            o_flush_valid <= bco_ok;
            o_flush_mask  <= bco_ok ? squash_mask : '0;
            if (err_set) begin
                o_err <= 1'b1;
            end
        end
    end

    assign o_alloc_ready = ready;
    assign o_alloc_bid   = wptr;
    assign o_count       = bid_t'(wptr - rptr);
    assign o_empty       = empty;
    assign o_full        = full;

endmodule

// File: tb/tb_issue_bid_alloc.sv
// Self-checking bench for issue_bid_alloc: directed scenarios followed by a
// randomized phase, all compared cycle by cycle against a queue-based model.
module tb_issue_bid_alloc;

    localparam int RC = 2;

    logic       clk;
    logic       resetn;
    logic       i_alloc_req;
    logic       o_alloc_ready;
    logic [3:0] o_alloc_bid;
    logic       i_bc_valid;
    logic [3:0] i_bc_bid;
    logic       i_bco_valid;
    logic [3:0] i_bco_bid;
    logic       o_flush_valid;
    logic [7:0] o_flush_mask;
    logic [3:0] o_count;
    logic       o_empty;
    logic       o_full;
    logic       o_err;

    int tests_run;
    int fail_count;

    // Reference model: in-flight branch IDs, oldest first.
    int         m_q[$];
    int         m_next;
    int         m_rec;
    bit         m_err;
    bit         m_fv;
    logic [7:0] m_fm;

    issue_bid_alloc #(.RECOVER_CYCLES(RC)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .i_alloc_req   (i_alloc_req),
        .o_alloc_ready (o_alloc_ready),
        .o_alloc_bid   (o_alloc_bid),
        .i_bc_valid    (i_bc_valid),
        .i_bc_bid      (i_bc_bid),
        .i_bco_valid   (i_bco_valid),
        .i_bco_bid     (i_bco_bid),
        .o_flush_valid (o_flush_valid),
        .o_flush_mask  (o_flush_mask),
        .o_count       (o_count),
        .o_empty       (o_empty),
        .o_full        (o_full),
        .o_err         (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_output("ready", 8'(o_alloc_ready), 8'((m_rec == 0) && (m_q.size() < 8)));
        check_output("bid",   8'(o_alloc_bid),   8'(m_next));
        check_output("count", 8'(o_count),       8'(m_q.size()));
        check_output("empty", 8'(o_empty),       8'(m_q.size() == 0));
        check_output("full",  8'(o_full),        8'(m_q.size() == 8));
        check_output("err",   8'(o_err),         8'(m_err));
        check_output("fv",    8'(o_flush_valid), 8'(m_fv));
        check_output("fmask", o_flush_mask,      m_fm);
    endtask

    // Advance the model by one clock given this cycle's inputs.
    task automatic model_step(input bit req, input bit bc, input logic [3:0] bcbid,
                              input bit bco, input logic [3:0] bcobid);
        bit         rdy;
        bit         fire;
        bit         bc_ok;
        bit         pair;
        bit         bco_ok;
        logic [7:0] fm;
        rdy   = (m_rec == 0) && (m_q.size() < 8);
        fire  = req && rdy;
        bc_ok = 1'b0;
        if (bc && m_q.size() > 0) bc_ok = (int'(bcbid) == m_q[0]);
        pair   = bc && (bcobid == bcbid);
        bco_ok = bco && pair && bc_ok;
        if ((bc && !bc_ok) || (bco && !pair)) m_err = 1'b1;
        fm = 8'h00;
        if (bco_ok) begin
            void'(m_q.pop_front());
            foreach (m_q[k]) fm[m_q[k] % 8] = 1'b1;
            if (fire) fm[m_next % 8] = 1'b1;
            m_q.delete();
            m_next = (int'(bcobid) + 1) % 16;
            m_rec  = RC;
        end else begin
            if (m_rec > 0) m_rec--;
            if (bc_ok) void'(m_q.pop_front());
            if (fire) begin
                m_q.push_back(m_next);
                m_next = (m_next + 1) % 16;
            end
        end
        m_fv = bco_ok;
        m_fm = fm;
    endtask

    task automatic apply_stimulus(input bit req, input bit bc, input logic [3:0] bcbid,
                                  input bit bco, input logic [3:0] bcobid);
        @(negedge clk);
        i_alloc_req = req;
        i_bc_valid  = bc;
        i_bc_bid    = bcbid;
        i_bco_valid = bco;
        i_bco_bid   = bcobid;
        model_step(req, bc, bcbid, bco, bcobid);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        i_alloc_req = 1'b0;
        i_bc_valid  = 1'b0;
        i_bc_bid    = 4'd0;
        i_bco_valid = 1'b0;
        i_bco_bid   = 4'd0;
        #1;
        m_q.delete();
        m_next = 0;
        m_rec  = 0;
        m_err  = 1'b0;
        m_fv   = 1'b0;
        m_fm   = 8'h00;
        check_all();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int r;
        bit req;
        bit bc;
        bit bco;
        logic [3:0] bcbid;
        logic [3:0] bcobid;
        tests_run  = 0;
        fail_count = 0;

        // Reset values
        do_reset();
        check_output("rst_ready", 8'(o_alloc_ready), 8'd1);
        check_output("rst_bid",   8'(o_alloc_bid),   8'd0);
        check_output("rst_empty", 8'(o_empty),       8'd1);

        // Fill to full with a held request
        for (int i = 0; i < 9; i++) apply_stimulus(1, 0, 0, 0, 0);
        check_output("fill_count", 8'(o_count),       8'd8);
        check_output("fill_full",  8'(o_full),        8'd1);
        check_output("fill_ready", 8'(o_alloc_ready), 8'd0);

        // Commit at full frees a slot; next grant carries the wrap bit
        apply_stimulus(1, 1, 4'd0, 0, 0);
        check_output("free_count", 8'(o_count),       8'd7);
        check_output("free_ready", 8'(o_alloc_ready), 8'd1);
        check_output("free_bid",   8'(o_alloc_bid),   8'd8);
        apply_stimulus(1, 0, 0, 0, 0);

        // Override on bid 3 with two younger branches
        do_reset();
        for (int i = 0; i < 6; i++) apply_stimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 4'(i), 0, 0);
        apply_stimulus(0, 1, 4'd3, 1, 4'd3);
        check_output("ovr_fv",    8'(o_flush_valid), 8'd1);
        check_output("ovr_mask",  o_flush_mask,      8'b0011_0000);
        check_output("ovr_count", 8'(o_count),       8'd0);
        check_output("ovr_ready", 8'(o_alloc_ready), 8'd0);
        apply_stimulus(1, 0, 0, 0, 0);
        check_output("rec_ready", 8'(o_alloc_ready), 8'd0);
        apply_stimulus(1, 0, 0, 0, 0);
        check_output("rec_done",  8'(o_alloc_ready), 8'd1);
        check_output("rec_bid",   8'(o_alloc_bid),   8'd4);
        apply_stimulus(1, 0, 0, 0, 0);

        // Override with a same-cycle allocation squashed
        do_reset();
        for (int i = 0; i < 6; i++) apply_stimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 4'(i), 0, 0);
        apply_stimulus(1, 1, 4'd3, 1, 4'd3);
        check_output("sq_mask",  o_flush_mask, 8'b0111_0000);
        check_output("sq_count", 8'(o_count),  8'd0);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("sq_fv_off", 8'(o_flush_valid), 8'd0);

        // Pointer wrap: rptr 14, wptr 2, override on bid 14
        do_reset();
        for (int i = 0; i < 8; i++) apply_stimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) apply_stimulus(0, 1, 4'(i), 0, 0);
        for (int i = 0; i < 6; i++) apply_stimulus(1, 0, 0, 0, 0);
        for (int i = 8; i < 14; i++) apply_stimulus(0, 1, 4'(i), 0, 0);
        for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 0, 0, 0);
        check_output("wrap_pre_bid", 8'(o_alloc_bid), 8'd2);
        apply_stimulus(0, 1, 4'd14, 1, 4'd14);
        check_output("wrap_mask",  o_flush_mask,    8'b1000_0011);
        check_output("wrap_bid",   8'(o_alloc_bid), 8'd15);
        check_output("wrap_count", 8'(o_count),     8'd0);
        for (int i = 0; i < RC; i++) apply_stimulus(0, 0, 0, 0, 0);

        // Protocol errors and reset during recovery
        do_reset();
        apply_stimulus(1, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0);
        apply_stimulus(0, 1, 4'd1, 0, 0);
        check_output("err_badbid", 8'(o_err),   8'd1);
        check_output("err_count",  8'(o_count), 8'd2);
        apply_stimulus(0, 0, 0, 1, 4'd0);
        check_output("err_sticky", 8'(o_err),         8'd1);
        check_output("err_nofv",   8'(o_flush_valid), 8'd0);
        apply_stimulus(0, 1, 4'd0, 1, 4'd0);
        check_output("err_rec", 8'(o_alloc_ready), 8'd0);
        do_reset();
        check_output("mid_ready", 8'(o_alloc_ready), 8'd1);
        check_output("mid_err",   8'(o_err),         8'd0);
        check_output("mid_fv",    8'(o_flush_valid), 8'd0);

        // Randomized traffic; protocol errors are injected only late in the run
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            r      = int'($urandom_range(0, 99));
            req    = (r < 60);
            bc     = 1'b0;
            bco    = 1'b0;
            bcbid  = 4'd0;
            bcobid = 4'd0;
            if (m_q.size() > 0 && int'($urandom_range(0, 99)) < 35) begin
                bc    = 1'b1;
                bcbid = 4'(m_q[0]);
                if (int'($urandom_range(0, 99)) < 10) begin
                    bco    = 1'b1;
                    bcobid = bcbid;
                end
            end
            if (cyc > 500 && int'($urandom_range(0, 99)) < 5) begin
                bc    = 1'b1;
                bcbid = 4'($urandom_range(0, 15));
            end
            if (cyc > 500 && int'($urandom_range(0, 99)) < 3) begin
                bco    = 1'b1;
                bcobid = 4'($urandom_range(0, 15));
            end
            apply_stimulus(req, bc, bcbid, bco, bcobid);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule

// File: doc/issue_bid_alloc.md
Name: issue_bid_alloc

Overview:
- Branch-ID allocator and recovery tracker for the issue stage; sits directly downstream of the branch record table.
- Hands out 4-bit branch IDs (3-bit table index plus wrap bit) to branches entering issue, and retires them in order on branch-commit.
- On a branch-commit override (mispredict), rolls the allocation pointer back and emits a registered flush mask of younger in-flight branches.
- Then blocks allocation for a fixed recovery window.

Parameters:
- RECOVER_CYCLES, 2, cycles o_alloc_ready stays low after a flush (legal 1..15).

Ports:
- clk  in  1  clock; all state updates on its rising edge
- resetn  in  1  asynchronous active-low reset
- i_alloc_req  in  1  issue stage requests a new branch ID this cycle
- o_alloc_ready  out  1  allocation accepted this cycle if i_alloc_req is high
- o_alloc_bid  out  4  ID granted when i_alloc_req & o_alloc_ready; equals wptr
- i_bc_valid  in  1  branch commit, from the record table's o_bc_valid
- i_bc_bid  in  4  committing branch ID
- i_bco_valid  in  1  commit override (mispredict), from o_bco_valid
- i_bco_bid  in  4  mispredicted branch ID
- o_flush_valid  out  1  one-cycle pulse: younger branches squashed
- o_flush_mask  out  8  one bit per table index [2:0] squashed
- o_count  out  4  in-flight branch count, 0..8
- o_empty  out  1  o_count == 0
- o_full  out  1  o_count == 8
- o_err  out  1  sticky protocol error

Behaviour:
- State: wptr[3:0], rptr[3:0], FSM {RUN, RECOVER}, recover counter, registered flush outputs, o_err.
- Count and flags: o_count = wptr - rptr (mod 16). Empty when pointers are fully equal. Full when indices are equal and wrap bits differ.
- Reset, asynchronous on resetn low:
  - wptr = rptr = 0, FSM = RUN, counter = 0.
  - o_flush_valid = 0, o_flush_mask = 0, o_err = 0.
  - Hence o_alloc_ready = 1, o_alloc_bid = 0, o_count = 0, o_empty = 1, o_full = 0.
  - Reset mid-recovery discards all state; no flush pulse is emitted.
- o_alloc_ready is combinational: (FSM == RUN) & ~o_full.
- Allocation fire = i_alloc_req & o_alloc_ready. On fire, wptr <= wptr + 1 (4-bit wrap, 15 -> 0).
- Commit (i_bc_valid):
  - Legal only when i_bc_bid == rptr and not empty; then rptr <= rptr + 1.
  - Any illegal commit sets o_err = 1 and leaves rptr unchanged.
- Override (i_bco_valid):
  - Always arrives in the same cycle as i_bc_valid with an equal bid; otherwise o_err = 1 and the override is ignored.
  - On a legal override: wptr <= i_bco_bid + 1, which equals the new rptr, so occupancy becomes 0.
  - Next cycle: o_flush_valid = 1. o_flush_mask holds bits for indices bco_bid+1 .. old_wptr-1 (circular, exclusive of old_wptr), plus the index of old_wptr if an allocation fired in the override cycle.
  - The same-cycle allocation is therefore squashed, not kept.
  - Mask is 0 when there are no younger branches; o_flush_valid still pulses.
- FSM:
  - RUN -> RECOVER on a legal override; counter loads RECOVER_CYCLES.
  - RECOVER: counter decrements each cycle; -> RUN when counter reaches 1, so ready is low for exactly RECOVER_CYCLES cycles starting the cycle after the override.
  - Commits during RECOVER are legal only if the table is non-empty; none are expected. An override in RECOVER with an empty table sets o_err.
- Same-cycle commit and allocation: both pointers advance; count is unchanged.
- A commit at full frees a slot; ready returns high the next cycle.
- o_flush_valid and o_flush_mask are 0 in every cycle other than the pulse.

Decomposition:
- Shared package issue_pkg:
  - BID_W = 4, BRT_DEPTH = 8, BRT_IDX_W = 3.
  - typedef bid_t (logic [3:0]); function bid_idx(bid) returning bid[2:0].
- One natural sub-module, issue_bid_flushmask: purely combinational; inputs start index, end pointer and same-cycle-alloc flag, output the 8-bit circular range mask. Kept separate so it can be exhaustively checked.

Test Plan:
- After reset, hold i_alloc_req for 9 cycles -> bids 0..7 granted, o_full = 1 at count 8, ready low on the 9th cycle, o_count = 8.
- From full, commit bid 0 -> next cycle count = 7, ready = 1; the next grant is bid 8 (index 0, wrap bit set).
- Allocate bids 0..5, commit 0..2, then bc+bco on bid 3 -> next cycle o_flush_valid = 1, o_flush_mask = 8'b0011_0000; count = 0; ready low 2 cycles; next grant = bid 4.
- Override on bid 3 with an allocation firing in the same cycle, old wptr = 6 -> mask = 8'b0111_0000; that allocation is not counted.
- Pointer wrap: rptr = 14, wptr = 2, override on bid 14 -> mask covers indices 7, 0, 1 = 8'b1000_0011; wptr = rptr = 15.
- Commit with bid != rptr, or bco without bc -> o_err = 1 and stays set; pointers unchanged; async resetn low mid-RECOVER clears all and ready = 1 immediately.
